// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the machine-mode trap path: sequencer states and
// the mcause encodings used by the trap controller.
package riscV_unrn_pkg;

  typedef enum logic [1:0] {
    RUN,
    TRAP_COMMIT,
    TRAP_REDIRECT,
    MRET_REDIRECT
  } trap_state_t;

  localparam logic [31:0] EXC_FETCH_MISALIGNED = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL          = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT       = 32'd3;
  localparam logic [31:0] EXC_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] EXC_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] EXC_ECALL_M          = 32'd11;
  localparam logic [31:0] IRQ_MTIMER           = 32'h8000_0007;

endpackage

// File: rtl/trap_controller_if.sv
// Bundle of commit-boundary, CSR-unit and fetch-redirect signals around the
// trap controller; the controller uses the slave view.
interface trap_controller_if #(
  parameter int XLEN = 32
);

  logic            instrValid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] badAddr_i;
  logic            excFetchMisaligned_i;
  logic            excIllegal_i;
  logic            excEbreak_i;
  logic            excEcall_i;
  logic            excLoadMisaligned_i;
  logic            excStoreMisaligned_i;
  logic            mret_i;
  logic            mtimeIrq_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;

  logic            flush_o;
  logic            stall_o;
  logic            jumpingToMtvec_o;
  logic [31:0]     excCause_o;
  logic [31:0]     trapInfo_o;
  logic [XLEN-1:0] trapPc_o;
  logic            mretRestore_o;
  logic            pcRedirect_o;
  logic [XLEN-1:0] pcTarget_o;

  modport master (
    output instrValid_i, pc_i, instr_i, badAddr_i,
           excFetchMisaligned_i, excIllegal_i, excEbreak_i, excEcall_i,
           excLoadMisaligned_i, excStoreMisaligned_i, mret_i, mtimeIrq_i,
           mtvec_i, mepc_i,
    input  flush_o, stall_o, jumpingToMtvec_o, excCause_o, trapInfo_o,
           trapPc_o, mretRestore_o, pcRedirect_o, pcTarget_o
  );

  modport slave (
    input  instrValid_i, pc_i, instr_i, badAddr_i,
           excFetchMisaligned_i, excIllegal_i, excEbreak_i, excEcall_i,
           excLoadMisaligned_i, excStoreMisaligned_i, mret_i, mtimeIrq_i,
           mtvec_i, mepc_i,
    output flush_o, stall_o, jumpingToMtvec_o, excCause_o, trapInfo_o,
           trapPc_o, mretRestore_o, pcRedirect_o, pcTarget_o
  );

endinterface

// File: rtl/trap_controller_cause_encoder.sv
// Combinational priority encoder: picks the highest-priority pending trap
// source and produces its mcause and mtval values.
module trap_cause_encoder
  import riscV_unrn_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            irq,
  input  logic            excFetchMisaligned,
  input  logic            excIllegal,
  input  logic            excEbreak,
  input  logic            excEcall,
  input  logic            excLoadMisaligned,
  input  logic            excStoreMisaligned,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] badAddr,
  output logic            valid,
  output logic [31:0]     cause,
  output logic [31:0]     info
);

  // The interrupt sits above every exception so an interrupted instruction
  // is simply never executed and is re-run after mret.
  always_comb begin
    valid = 1'b1;
    cause = '0;
    info  = '0;
    if (irq) begin
      cause = IRQ_MTIMER;
    end else if (excFetchMisaligned) begin
      cause = EXC_FETCH_MISALIGNED;
      info  = 32'(badAddr);
    end else if (excIllegal) begin
      cause = EXC_ILLEGAL;
      info  = instr;
    end else if (excEbreak) begin
      cause = EXC_BREAKPOINT;
      info  = 32'(pc);
    end else if (excEcall) begin
      cause = EXC_ECALL_M;
    end else if (excLoadMisaligned) begin
      cause = EXC_LOAD_MISALIGNED;
      info  = 32'(badAddr);
    end else if (excStoreMisaligned) begin
      cause = EXC_STORE_MISALIGNED;
      info  = 32'(badAddr);
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap entry / mret sequencer for the machine-mode CSR unit: detects traps at
// the commit boundary, strobes the CSR unit, then redirects fetch.
module trap_controller
  import riscV_unrn_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit TIMER_IRQ_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  trap_controller_if.slave  bus
);

  trap_state_t     state_q, state_d;
  logic            irq;
  logic            encValid;
  logic [31:0]     encCause;
  logic [31:0]     encInfo;
  logic            trapDet;
  logic            mretDet;
  logic [31:0]     causeQ;
  logic [31:0]     infoQ;
  logic [XLEN-1:0] trapPcQ;

  logic            flush;
  logic            stall;
  logic            jump;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            restore;

  assign irq = TIMER_IRQ_EN && bus.mtimeIrq_i;

  trap_cause_encoder #(.XLEN(XLEN)) u_encoder (
    .irq                (irq),
    .excFetchMisaligned (bus.excFetchMisaligned_i),
    .excIllegal         (bus.excIllegal_i),
    .excEbreak          (bus.excEbreak_i),
    .excEcall           (bus.excEcall_i),
    .excLoadMisaligned  (bus.excLoadMisaligned_i),
    .excStoreMisaligned (bus.excStoreMisaligned_i),
    .pc                 (bus.pc_i),
    .instr              (bus.instr_i),
    .badAddr            (bus.badAddr_i),
    .valid              (encValid),
    .cause              (encCause),
    .info               (encInfo)
  );

  assign trapDet = bus.instrValid_i & encValid;
  assign mretDet = bus.instrValid_i & bus.mret_i & ~encValid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      causeQ  <= '0;
      infoQ   <= '0;
      trapPcQ <= '0;
    end else if (state_q == RUN && trapDet) begin
      causeQ  <= encCause;
      infoQ   <= encInfo;
      trapPcQ <= bus.pc_i;
    end
  end

  // Non-RUN states never look at the trap sources, which rules out nesting.
  always_comb begin
    state_d  = state_q;
    flush    = 1'b0;
    stall    = 1'b0;
    jump     = 1'b0;
    redirect = 1'b0;
    target   = '0;
    restore  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (trapDet) begin
          flush   = 1'b1;
          stall   = 1'b1;
          state_d = TRAP_COMMIT;
        end else if (mretDet) begin
          stall   = 1'b1;
          state_d = MRET_REDIRECT;
        end
      end
      TRAP_COMMIT: begin
        jump    = 1'b1;
        stall   = 1'b1;
        state_d = TRAP_REDIRECT;
      end
      TRAP_REDIRECT: begin
        redirect = 1'b1;
        target   = bus.mtvec_i;
        stall    = 1'b1;
        state_d  = RUN;
      end
      MRET_REDIRECT: begin
        redirect = 1'b1;
        target   = bus.mepc_i;
        restore  = 1'b1;
        stall    = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Detection outputs are combinational, so hold them low while in reset.
  assign bus.flush_o          = flush & rst;
  assign bus.stall_o          = stall & rst;
  assign bus.jumpingToMtvec_o = jump;
  assign bus.excCause_o       = causeQ;
  assign bus.trapInfo_o       = infoQ;
  assign bus.trapPc_o         = trapPcQ;
  assign bus.mretRestore_o    = restore;
  assign bus.pcRedirect_o     = redirect;
  assign bus.pcTarget_o       = target;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench: two controllers (timer irq enabled / tied off) share
// stimulus and are compared every cycle against a schedule-based model.
module tb_trap_controller;

  localparam logic [5:0] E_FM = 6'b100000;
  localparam logic [5:0] E_IL = 6'b010000;
  localparam logic [5:0] E_EB = 6'b001000;
  localparam logic [5:0] E_EC = 6'b000100;
  localparam logic [5:0] E_LM = 6'b000010;
  localparam logic [5:0] E_SM = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        instrValid;
  logic [31:0] pc, instr, badAddr, mtvec, mepc;
  logic [5:0]  exc;
  logic        mret, mtimeIrq;

  int total = 0;
  int bad   = 0;

  // Model: per DUT a two-slot schedule of upcoming actions
  // (0 none, 1 strobe, 2 redirect to mtvec, 3 redirect to mepc) and the
  // cause/info/pc the DUT should be presenting.
  int          pend [2][2];
  logic [31:0] heldCause [2];
  logic [31:0] heldInfo  [2];
  logic [31:0] heldPc    [2];

  trap_controller_if #(.XLEN(32)) busA ();
  trap_controller_if #(.XLEN(32)) busB ();

  trap_controller #(.XLEN(32), .TIMER_IRQ_EN(1'b1)) dutA (
    .clk (clk), .rst (rst), .bus (busA)
  );
  trap_controller #(.XLEN(32), .TIMER_IRQ_EN(1'b0)) dutB (
    .clk (clk), .rst (rst), .bus (busB)
  );

  assign busA.instrValid_i = instrValid;          assign busB.instrValid_i = instrValid;
  assign busA.pc_i = pc;                          assign busB.pc_i = pc;
  assign busA.instr_i = instr;                    assign busB.instr_i = instr;
  assign busA.badAddr_i = badAddr;                assign busB.badAddr_i = badAddr;
  assign busA.excFetchMisaligned_i = exc[5];      assign busB.excFetchMisaligned_i = exc[5];
  assign busA.excIllegal_i = exc[4];              assign busB.excIllegal_i = exc[4];
  assign busA.excEbreak_i = exc[3];               assign busB.excEbreak_i = exc[3];
  assign busA.excEcall_i = exc[2];                assign busB.excEcall_i = exc[2];
  assign busA.excLoadMisaligned_i = exc[1];       assign busB.excLoadMisaligned_i = exc[1];
  assign busA.excStoreMisaligned_i = exc[0];      assign busB.excStoreMisaligned_i = exc[0];
  assign busA.mret_i = mret;                      assign busB.mret_i = mret;
  assign busA.mtimeIrq_i = mtimeIrq;              assign busB.mtimeIrq_i = mtimeIrq;
  assign busA.mtvec_i = mtvec;                    assign busB.mtvec_i = mtvec;
  assign busA.mepc_i = mepc;                      assign busB.mepc_i = mepc;

  task automatic check(input string tag, input int k,
                       input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d: got %0h want %0h", tag, k, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p,
                               input logic [31:0] ins, input logic [31:0] ba,
                               input logic [5:0] e, input logic mr, input logic ir);
    instrValid = v; pc = p; instr = ins; badAddr = ba;
    exc = e; mret = mr; mtimeIrq = ir;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b0, 1'b0);
  endtask

  // Highest-priority trap among the current inputs, scanned in priority order.
  task automatic pickTrap(input int k, output bit found,
                          output logic [31:0] cause, output logic [31:0] info);
    bit          conds  [7];
    logic [31:0] causes [7];
    logic [31:0] infos  [7];
    conds  = '{(k == 0) && mtimeIrq, exc[5], exc[4], exc[3], exc[2], exc[1], exc[0]};
    causes = '{32'h8000_0007, 32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
    infos  = '{32'h0, badAddr, instr, pc, 32'h0, badAddr, badAddr};
    found = 1'b0; cause = '0; info = '0;
    for (int i = 0; i < 7; i++) begin
      if (conds[i] && !found) begin
        found = 1'b1; cause = causes[i]; info = infos[i];
      end
    end
  endtask

  task automatic checkOutput();
    logic        oFlush, oStall, oJump, oRestore, oRedir;
    logic [31:0] oCause, oInfo, oPc, oTarget;
    logic        eFlush, eStall, eJump, eRestore, eRedir;
    logic [31:0] eTarget, tCause, tInfo;
    bit          found;
    int          tok;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        oFlush = busA.flush_o; oStall = busA.stall_o; oJump = busA.jumpingToMtvec_o;
        oCause = busA.excCause_o; oInfo = busA.trapInfo_o; oPc = busA.trapPc_o;
        oRestore = busA.mretRestore_o; oRedir = busA.pcRedirect_o; oTarget = busA.pcTarget_o;
      end else begin
        oFlush = busB.flush_o; oStall = busB.stall_o; oJump = busB.jumpingToMtvec_o;
        oCause = busB.excCause_o; oInfo = busB.trapInfo_o; oPc = busB.trapPc_o;
        oRestore = busB.mretRestore_o; oRedir = busB.pcRedirect_o; oTarget = busB.pcTarget_o;
      end
      eFlush = 1'b0; eStall = 1'b0; eJump = 1'b0; eRestore = 1'b0; eRedir = 1'b0;
      eTarget = '0; found = 1'b0; tCause = '0; tInfo = '0;
      tok = 0;
      if (!rst) begin
        pend[k][0] = 0; pend[k][1] = 0;
        heldCause[k] = '0; heldInfo[k] = '0; heldPc[k] = '0;
      end else begin
        tok = pend[k][0];
        pend[k][0] = pend[k][1];
        pend[k][1] = 0;
        case (tok)
          1: begin eJump = 1'b1; eStall = 1'b1; end
          2: begin eRedir = 1'b1; eStall = 1'b1; eTarget = mtvec; end
          3: begin eRedir = 1'b1; eStall = 1'b1; eTarget = mepc; eRestore = 1'b1; end
          default: begin
            pickTrap(k, found, tCause, tInfo);
            if (instrValid && found) begin
              eFlush = 1'b1; eStall = 1'b1;
              pend[k][0] = 1; pend[k][1] = 2;
            end else if (instrValid && mret) begin
              eStall = 1'b1;
              pend[k][0] = 3;
            end
          end
        endcase
      end
      check("flush", k, 64'(oFlush), 64'(eFlush));
      check("stall", k, 64'(oStall), 64'(eStall));
      check("strobe", k, 64'(oJump), 64'(eJump));
      check("cause", k, 64'(oCause), 64'(heldCause[k]));
      check("info", k, 64'(oInfo), 64'(heldInfo[k]));
      check("trapPc", k, 64'(oPc), 64'(heldPc[k]));
      check("restore", k, 64'(oRestore), 64'(eRestore));
      check("redirect", k, 64'(oRedir), 64'(eRedir));
      check("target", k, 64'(oTarget), 64'(eTarget));
      if (eFlush) begin
        heldCause[k] = tCause; heldInfo[k] = tInfo; heldPc[k] = pc;
      end
    end
  endtask

  task automatic tick();
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k][0] = 0; pend[k][1] = 0;
      heldCause[k] = '0; heldInfo[k] = '0; heldPc[k] = '0;
    end
    rst = 1'b0; mtvec = 32'h200; mepc = 32'h104;
    clearInputs();
    @(negedge clk);
    tick(); tick();
    rst = 1'b1;
    tick();

    // ecall at 0x100 with mtvec 0x200, then four cycles of sequencing
    applyStimulus(1'b1, 32'h100, 32'h0000_0073, 32'h0, E_EC, 1'b0, 1'b0);
    tick();
    clearInputs();
    tick(); tick(); tick();

    // illegal instruction, all-ones encoding
    applyStimulus(1'b1, 32'h40, 32'hFFFF_FFFF, 32'h0, E_IL, 1'b0, 1'b0);
    tick();
    clearInputs();
    tick(); tick(); tick();

    // timer irq together with ecall; also a pending mret loses to the trap
    applyStimulus(1'b1, 32'h80, 32'h0000_0073, 32'h0, E_EC, 1'b1, 1'b1);
    tick();
    clearInputs();
    tick(); tick(); tick();

    // mret to 0x104
    mepc = 32'h104;
    applyStimulus(1'b1, 32'h300, 32'h3020_0073, 32'h0, 6'b0, 1'b1, 1'b0);
    tick();
    clearInputs();
    tick(); tick();

    // pending irq without a valid instruction, then taken on the first valid one
    applyStimulus(1'b0, 32'h500, 32'h0, 32'h0, 6'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    applyStimulus(1'b1, 32'h504, 32'h13, 32'h0, 6'b0, 1'b0, 1'b1);
    tick();
    clearInputs();
    tick();
    applyStimulus(1'b1, 32'h508, 32'h0, 32'h0, E_IL | E_LM, 1'b0, 1'b1);
    tick();
    clearInputs();
    tick(); tick();

    // reset in the strobe cycle aborts the trap
    applyStimulus(1'b1, 32'h600, 32'h0, 32'h0, E_EB, 1'b0, 1'b0);
    tick();
    clearInputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick(); tick();

    // misaligned sources carry badAddr
    applyStimulus(1'b1, 32'h700, 32'h0, 32'hDEAD_BEE1, E_LM | E_SM, 1'b0, 1'b0);
    tick();
    clearInputs();
    tick(); tick();
    applyStimulus(1'b1, 32'h704, 32'h0, 32'h0000_0702, E_FM | E_EC, 1'b0, 1'b0);
    tick();
    clearInputs();
    tick(); tick();

    // randomized traffic, including occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) != 0);
      mtvec = $urandom & 32'hFFFF_FFFC;
      mepc  = $urandom & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
                    $urandom,
                    {$urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0},
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b1;
    clearInputs();
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
Sequences trap entry and return for the machine-mode CSR unit.
- Samples synchronous exceptions from decode/execute and the timer interrupt request at instruction boundaries.
- Prioritises them and drives the CSR unit's trap-entry strobe, cause, trap value and faulting PC.
- Redirects fetch to mtvec on trap entry and to mepc on mret, stalling the pipeline while a trap or return is in flight.

Parameters:
XLEN, 32, datapath/CSR width
TIMER_IRQ_EN, 1, 0 ties off timer interrupt sampling

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
instrValid_i  in  1  an instruction is at the commit boundary this cycle
pc_i  in  XLEN  PC of that instruction
instr_i  in  32  instruction bits
badAddr_i  in  XLEN  faulting address for misaligned fetch/load/store
excFetchMisaligned_i  in  1  fetch misaligned
excIllegal_i  in  1  illegal instruction
excEbreak_i  in  1  ebreak
excEcall_i  in  1  ecall
excLoadMisaligned_i  in  1  load misaligned
excStoreMisaligned_i  in  1  store misaligned
mret_i  in  1  instruction is mret
mtimeIrq_i  in  1  timer interrupt pending and enabled (CSR unit mtime_exc_o)
mtvec_i  in  XLEN  trap vector from CSR unit
mepc_i  in  XLEN  return address from CSR unit
flush_o  out  1  combinational: suppress writeback of the current instruction
stall_o  out  1  freeze fetch/decode
jumpingToMtvec_o  out  1  one-cycle trap-entry strobe to CSR unit
excCause_o  out  32  mcause value
trapInfo_o  out  32  mtval value
trapPc_o  out  XLEN  mepc value
mretRestore_o  out  1  one-cycle pulse: CSR unit restores mstatus.mie
pcRedirect_o  out  1  one-cycle fetch redirect
pcTarget_o  out  XLEN  redirect target

Behaviour:
- Reset (rst=0, async): state RUN. All outputs 0. Latched cause/info/pc cleared. Reset mid-trap aborts with no strobe or redirect.
- States: RUN, TRAP_COMMIT, TRAP_REDIRECT, MRET_REDIRECT.
- RUN, trap detect: trap = instrValid_i & (irq | any exc), where irq = TIMER_IRQ_EN & mtimeIrq_i.
  - flush_o=1 and stall_o=1 combinationally.
  - Latch cause, info and pc_i.
  - Next state TRAP_COMMIT.
- RUN, mret: instrValid_i & mret_i & ~trap → MRET_REDIRECT; stall_o=1.
- RUN, otherwise: outputs 0. instrValid_i=0 samples nothing; a pending irq waits for the next valid instruction.
- Priority (highest first):
  - irq (cause 0x8000_0007, info 0)
  - fetch misaligned (0, badAddr)
  - illegal (2, instr_i)
  - ebreak (3, pc_i)
  - ecall (11, 0)
  - load misaligned (4, badAddr)
  - store misaligned (6, badAddr)
- Irq beats a same-cycle exception; the instruction is not executed and trapPc = its pc.
- Any trap beats a same-cycle mret.
- TRAP_COMMIT, 1 cycle: jumpingToMtvec_o=1; excCause_o/trapInfo_o/trapPc_o = latched values; stall_o=1; → TRAP_REDIRECT.
- TRAP_REDIRECT, 1 cycle: pcRedirect_o=1, pcTarget_o=mtvec_i (sampled this cycle, after the CSR unit has cleared mie); stall_o=1; → RUN.
- MRET_REDIRECT, 1 cycle: pcRedirect_o=1, pcTarget_o=mepc_i, mretRestore_o=1, stall_o=1; → RUN.
- Non-RUN states ignore all exc/irq/mret inputs; no nesting.
- Latency: detect at cycle N, strobe at N+1, redirect at N+2; mret redirect at N+1.
- excCause_o/trapInfo_o/trapPc_o hold their latched value outside TRAP_COMMIT; consumers qualify on the strobe.

Decomposition:
- Package riscV_unrn_pkg gains:
  - trap_state_t enum
  - cause constants EXC_FETCH_MISALIGNED=0, EXC_ILLEGAL=2, EXC_BREAKPOINT=3, EXC_LOAD_MISALIGNED=4, EXC_STORE_MISALIGNED=6, EXC_ECALL_M=11, IRQ_MTIMER=32'h8000_0007
- Sub-module trap_cause_encoder: combinational priority encoder producing {valid, cause, info}.

Test Plan:
- Reset asserted mid-TRAP_COMMIT → all outputs 0 immediately; state RUN after release; no redirect.
- ecall, pc 0x100, mtvec 0x200 → N: flush/stall; N+1: strobe, cause 11, trapPc 0x100, info 0; N+2: redirect to 0x200; N+3: stall 0.
- Illegal, instr 0xFFFF_FFFF at pc 0x40 → cause 2, trapInfo 0xFFFF_FFFF, trapPc 0x40.
- mtimeIrq_i with ecall in the same cycle, pc 0x80 → cause 0x8000_0007, trapPc 0x80. Repeat with TIMER_IRQ_EN=0 → cause 11.
- mret with mepc 0x104 → N+1: pcRedirect to 0x104, mretRestore pulse, no strobe.
- mtimeIrq_i high while instrValid_i=0 for 3 cycles → no activity; trap taken on the first valid cycle. Exc asserted during TRAP_REDIRECT → ignored.
